// File: rtl/estu_result_uart_tx.sv
// 8N1 UART transmitter for ESTU last-layer results: a small FIFO buffers result words,
// and each word is sent as two bytes, high byte first, with no idle gap between queued words.
module estu_result_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int DATA_W       = 13
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_txd,
    output logic              o_busy,
    output logic              o_full,
    output logic              o_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [15:0]       baud;
    logic [2:0]        bit_idx;
    logic              byte_sel_lo;
    logic [DATA_W-1:0] word;
    logic [15:0]       word_ext;
    logic [7:0]        cur_byte;
    logic              empty;
    logic              push;
    logic              pop;
    logic              bit_end;

    assign empty    = (count == '0);
    assign o_full   = (count == DEPTH_CNT);
    assign push     = i_valid && !o_full;
    assign bit_end  = (baud == BAUD_LAST);
    // A word leaves the FIFO either from IDLE or at the very end of a low byte's stop bit.
    assign pop      = !empty && ((state == IDLE) || (state == STOP && bit_end && byte_sel_lo));
    assign word_ext = 16'(word);
    assign cur_byte = byte_sel_lo ? word_ext[7:0] : word_ext[15:8];

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
            if (i_valid && o_full) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // o_txd/o_busy are registered from the current state, so the line lags the state by one clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            baud        <= '0;
            bit_idx     <= '0;
            byte_sel_lo <= 1'b0;
            word        <= '0;
            o_txd       <= 1'b1;
            o_busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_txd   <= 1'b1;
                    o_busy  <= 1'b0;
                    baud    <= '0;
                    bit_idx <= '0;
                    if (!empty) begin
                        word        <= mem[rd_ptr];
                        byte_sel_lo <= 1'b0;
                        state       <= START;
                    end
                end
                START: begin
                    o_txd  <= 1'b0;
                    o_busy <= 1'b1;
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                DATA: begin
                    o_txd  <= cur_byte[bit_idx];
                    o_busy <= 1'b1;
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                STOP: begin
                    o_txd  <= 1'b1;
                    o_busy <= 1'b1;
                    if (bit_end) begin
                        baud <= '0;
                        if (!byte_sel_lo) begin
                            byte_sel_lo <= 1'b1;
                            state       <= START;
                        end else if (!empty) begin
                            word        <= mem[rd_ptr];
                            byte_sel_lo <= 1'b0;
                            state       <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_estu_result_uart_tx.sv
// Bench for estu_result_uart_tx: a UART line decoder per instance feeds received bytes back,
// and each scenario compares them against bytes it queued when driving the result strobe.
module tb_estu_result_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;
    logic [12:0] data_a = '0;
    logic [12:0] data_b = '0;
    logic        txd_a, busy_a, full_a, ovf_a;
    logic        txd_b, busy_b, full_b, ovf_b;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        logic [7:0] data;
        bit         ok;
        int         start;
    } rx_t;

    rx_t        rx_a[$];
    rx_t        rx_b[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    estu_result_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .DATA_W(13)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_a), .i_data(data_a),
        .o_txd(txd_a), .o_busy(busy_a), .o_full(full_a), .o_overflow(ovf_a)
    );

    estu_result_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(8), .DATA_W(13)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_b), .i_data(data_b),
        .o_txd(txd_b), .o_busy(busy_b), .o_full(full_b), .o_overflow(ovf_b)
    );

    function automatic logic line(input int which);
        return (which == 0) ? txd_a : txd_b;
    endfunction

    // Decoder samples every falling clock edge; ok clears if any bit is not exactly cpb samples wide.
    task automatic rx_monitor(input int which, input int cpb);
        rx_t        r;
        logic [7:0] b;
        bit         ok;
        int         st;
        forever begin
            @(negedge clk);
            if (line(which) === 1'b0) begin
                st = cycle;
                ok = 1'b1;
                b  = '0;
                for (int s = 1; s < cpb; s++) begin
                    @(negedge clk);
                    if (line(which) !== 1'b0) ok = 1'b0;
                end
                for (int i = 0; i < 8; i++) begin
                    for (int s = 0; s < cpb; s++) begin
                        @(negedge clk);
                        if (s == 0) b[i] = line(which);
                        else if (line(which) !== b[i]) ok = 1'b0;
                    end
                end
                for (int s = 0; s < cpb; s++) begin
                    @(negedge clk);
                    if (line(which) !== 1'b1) ok = 1'b0;
                end
                r.data  = b;
                r.ok    = ok;
                r.start = st;
                if (which == 0) rx_a.push_back(r);
                else rx_b.push_back(r);
            end
        end
    endtask

    initial rx_monitor(0, 4);
    initial rx_monitor(1, 2);

    task automatic wait_rx(input int which, input int n, input int budget);
        int i = 0;
        while ((((which == 0) ? rx_a.size() : rx_b.size()) < n) && (i < budget)) begin
            @(negedge clk);
            i++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (txd_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_txd got %b want 1", txd_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy_a); end
        checks++; if (full_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b want 0", full_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b want 0", ovf_a); end
        checks++; if (txd_b !== 1'b1) begin errors++; $display("[TB] FAIL reset_txd_b got %b want 1", txd_b); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_after_reset txd=%b busy=%b want 1/0", txd_a, busy_a);
        end
    endtask

    task automatic test_single();
        int         e;
        int         nbusy = 0;
        int         first_busy = -1;
        rx_t        r;
        logic [7:0] x;
        @(negedge clk);
        valid_a = 1'b1; data_a = 13'h1ABC; e = cycle + 1;
        exp_a.push_back(8'h1A); exp_a.push_back(8'hBC);
        @(negedge clk);
        valid_a = 1'b0; data_a = 13'h0F0F;
        for (int i = 0; i < 150; i++) begin
            if (busy_a === 1'b1) begin
                nbusy++;
                if (first_busy < 0) first_busy = cycle;
            end
            @(negedge clk);
        end
        checks++; if (nbusy != 80) begin errors++; $display("[TB] FAIL single_busy_len got %0d want 80", nbusy); end
        checks++; if (first_busy != e + 2) begin errors++; $display("[TB] FAIL single_busy_rise got %0d want %0d", first_busy, e + 2); end
        wait_rx(0, 2, 200);
        checks++; if (rx_a.size() != 2) begin errors++; $display("[TB] FAIL single_count got %0d want 2", rx_a.size()); end
        for (int k = 0; k < 2; k++) begin
            if (rx_a.size() == 0 || exp_a.size() == 0) break;
            r = rx_a.pop_front(); x = exp_a.pop_front();
            checks++; if (r.data !== x) begin errors++; $display("[TB] FAIL single_byte%0d got %h want %h", k, r.data, x); end
            checks++; if (!r.ok) begin errors++; $display("[TB] FAIL single_frame%0d got bad framing want clean", k); end
            if (k == 0) begin
                checks++; if (r.start != e + 2) begin errors++; $display("[TB] FAIL single_txd_fall got %0d want %0d", r.start, e + 2); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int         e;
        int         s0 = 0;
        int         nbusy = 0;
        int         falls = 0;
        logic       prev = 1'b0;
        rx_t        r;
        logic [7:0] x;
        @(negedge clk);
        valid_a = 1'b1; data_a = 13'h0001; e = cycle + 1;
        exp_a.push_back(8'h00); exp_a.push_back(8'h01);
        @(negedge clk);
        valid_a = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i == 9) begin
                valid_a = 1'b1; data_a = 13'h1FFF;
                exp_a.push_back(8'h1F); exp_a.push_back(8'hFF);
            end
            if (i == 10) valid_a = 1'b0;
            if (busy_a === 1'b1) nbusy++;
            if (prev === 1'b1 && busy_a === 1'b0) falls++;
            prev = busy_a;
            @(negedge clk);
        end
        checks++; if (nbusy != 160) begin errors++; $display("[TB] FAIL b2b_busy_len got %0d want 160", nbusy); end
        checks++; if (falls != 1) begin errors++; $display("[TB] FAIL b2b_busy_gaps got %0d falls want 1", falls); end
        wait_rx(0, 4, 200);
        checks++; if (rx_a.size() != 4) begin errors++; $display("[TB] FAIL b2b_count got %0d want 4", rx_a.size()); end
        for (int k = 0; k < 4; k++) begin
            if (rx_a.size() == 0 || exp_a.size() == 0) break;
            r = rx_a.pop_front(); x = exp_a.pop_front();
            if (k == 0) begin
                s0 = r.start;
                checks++; if (s0 != e + 2) begin errors++; $display("[TB] FAIL b2b_first_start got %0d want %0d", s0, e + 2); end
            end else begin
                checks++; if (r.start != s0 + 40 * k) begin errors++; $display("[TB] FAIL b2b_start%0d got %0d want %0d", k, r.start, s0 + 40 * k); end
            end
            checks++; if (r.data !== x || !r.ok) begin errors++; $display("[TB] FAIL b2b_byte%0d got %h ok=%0d want %h ok=1", k, r.data, r.ok, x); end
        end
    endtask

    task automatic test_overflow();
        int         mcount = 0;
        bit         efull = 1'b0;
        bit         eovf = 1'b0;
        logic [12:0] w;
        rx_t        r;
        logic [7:0] x;
        int         n;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (full_a !== efull) begin errors++; $display("[TB] FAIL ovf_full_after%0d got %b want %b", i - 1, full_a, efull); end
                checks++; if (ovf_a !== eovf) begin errors++; $display("[TB] FAIL ovf_flag_after%0d got %b want %b", i - 1, ovf_a, eovf); end
            end
            w = 13'(i);
            valid_a = 1'b1; data_a = w;
            // The idle transmitter takes the first word out one edge after it lands.
            if (mcount < 8) begin
                exp_a.push_back({3'b000, w[12:8]}); exp_a.push_back(w[7:0]);
                mcount++;
            end else begin
                eovf = 1'b1;
            end
            if (i == 1) mcount--;
            efull = (mcount == 8);
        end
        @(negedge clk);
        valid_a = 1'b0;
        checks++; if (full_a !== efull) begin errors++; $display("[TB] FAIL ovf_full_after9 got %b want %b", full_a, efull); end
        checks++; if (ovf_a !== eovf) begin errors++; $display("[TB] FAIL ovf_flag_after9 got %b want %b", ovf_a, eovf); end
        n = exp_a.size();
        wait_rx(0, n, 1000);
        repeat (5) @(negedge clk);
        checks++; if (rx_a.size() != n) begin errors++; $display("[TB] FAIL ovf_count got %0d want %0d", rx_a.size(), n); end
        for (int k = 0; k < n; k++) begin
            if (rx_a.size() == 0 || exp_a.size() == 0) break;
            r = rx_a.pop_front(); x = exp_a.pop_front();
            checks++; if (r.data !== x || !r.ok) begin errors++; $display("[TB] FAIL ovf_byte%0d got %h ok=%0d want %h", k, r.data, r.ok, x); end
        end
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b want 1", ovf_a); end
        checks++; if (full_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("[TB] FAIL ovf_drained full=%b busy=%b want 0/0", full_a, busy_a);
        end
        do_reset();
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cleared got %b want 0", ovf_a); end
    endtask

    task automatic test_pop_collision();
        int          e;
        logic [12:0] w;
        rx_t         r;
        logic [7:0]  x;
        int          n;
        @(negedge clk);
        e = cycle + 1;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            w = (k == 0) ? 13'h0AAA : 13'(13'h0100 + k);
            valid_a = 1'b1; data_a = w;
            exp_a.push_back({3'b000, w[12:8]}); exp_a.push_back(w[7:0]);
        end
        @(negedge clk);
        valid_a = 1'b0;
        while (cycle < e + 80) @(negedge clk);
        checks++; if (full_a !== 1'b1 || ovf_a !== 1'b0) begin
            errors++; $display("[TB] FAIL coll_before full=%b ovf=%b want 1/0", full_a, ovf_a);
        end
        // This push meets the edge where the first word's stop bit ends and the next word is popped.
        valid_a = 1'b1; data_a = 13'h1555;
        @(negedge clk);
        valid_a = 1'b0;
        checks++; if (full_a !== 1'b0) begin errors++; $display("[TB] FAIL coll_full got %b want 0", full_a); end
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("[TB] FAIL coll_overflow got %b want 1", ovf_a); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL coll_busy got %b want 1", busy_a); end
        n = exp_a.size();
        wait_rx(0, n, 1000);
        repeat (100) @(negedge clk);
        checks++; if (rx_a.size() != n) begin errors++; $display("[TB] FAIL coll_count got %0d want %0d", rx_a.size(), n); end
        for (int k = 0; k < n; k++) begin
            if (rx_a.size() == 0 || exp_a.size() == 0) break;
            r = rx_a.pop_front(); x = exp_a.pop_front();
            if (k == 2) begin
                checks++; if (r.start != e + 82) begin errors++; $display("[TB] FAIL coll_gapless got %0d want %0d", r.start, e + 82); end
            end
            checks++; if (r.data !== x || !r.ok) begin errors++; $display("[TB] FAIL coll_byte%0d got %h ok=%0d want %h", k, r.data, r.ok, x); end
        end
        rx_a.delete();
        do_reset();
    endtask

    task automatic test_reset_midframe();
        int e;
        int rc;
        int after = 0;
        int nbusy = 0;
        @(negedge clk);
        valid_a = 1'b1; data_a = 13'h1234; e = cycle + 1;
        @(negedge clk);
        data_a = 13'h0567;
        @(negedge clk);
        valid_a = 1'b0;
        while (cycle < e + 19) @(negedge clk);
        checks++; if (txd_a !== 1'b0) begin errors++; $display("[TB] FAIL mid_bit3 got %b want 0", txd_a); end
        #1 rst_n = 1'b0;
        #1;
        rc = cycle;
        checks++; if (txd_a !== 1'b1) begin errors++; $display("[TB] FAIL mid_txd_async got %b want 1", txd_a); end
        checks++; if (busy_a !== 1'b0 || full_a !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_state busy=%b full=%b want 0/0", busy_a, full_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy_a === 1'b1) nbusy++;
        end
        foreach (rx_a[k]) if (rx_a[k].start >= rc) after++;
        checks++; if (after != 0) begin errors++; $display("[TB] FAIL mid_no_more_bytes got %0d want 0", after); end
        checks++; if (nbusy != 0) begin errors++; $display("[TB] FAIL mid_busy_after got %0d want 0", nbusy); end
        rx_a.delete();
    endtask

    task automatic test_cpb2();
        int         e;
        int         nbusy = 0;
        rx_t        r;
        logic [7:0] x;
        @(negedge clk);
        valid_b = 1'b1; data_b = 13'h0055; e = cycle + 1;
        exp_b.push_back(8'h00); exp_b.push_back(8'h55);
        @(negedge clk);
        valid_b = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (busy_b === 1'b1) nbusy++;
            @(negedge clk);
        end
        checks++; if (nbusy != 40) begin errors++; $display("[TB] FAIL cpb2_busy_len got %0d want 40", nbusy); end
        wait_rx(1, 2, 100);
        checks++; if (rx_b.size() != 2) begin errors++; $display("[TB] FAIL cpb2_count got %0d want 2", rx_b.size()); end
        for (int k = 0; k < 2; k++) begin
            if (rx_b.size() == 0 || exp_b.size() == 0) break;
            r = rx_b.pop_front(); x = exp_b.pop_front();
            checks++; if (r.data !== x || !r.ok) begin errors++; $display("[TB] FAIL cpb2_byte%0d got %h ok=%0d want %h ok=1", k, r.data, r.ok, x); end
            checks++; if (r.start != e + 2 + 20 * k) begin errors++; $display("[TB] FAIL cpb2_start%0d got %0d want %0d", k, r.start, e + 2 + 20 * k); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_pop_collision();
        test_reset_midframe();
        test_cpb2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

endmodule
